// File: rtl/load_store_buffer_pkg.sv
// Shared definitions for the load/store buffer.
// Holds the queue geometry, the tag width, the RISC-V funct3 width codes,
// the memory-size codes, the FSM state encoding and the queue entry layout.
// Helpers:
//   funct3_to_len : maps a load/store funct3 onto the memory size code
//   snoop         : applies result-bus wakeup to one entry
package load_store_buffer_pkg;

  localparam int DEPTH = 16;
  localparam int PTR_W = 4;
  localparam int CNT_W = 5;
  localparam int TAG_W = 5;

  // funct3 width/sign codes
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // mem_len codes
  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2,
    ST_DRAIN = 2'd3
  } lsb_state_e;

  typedef struct packed {
    logic             store;
    logic [2:0]       funct3;
    logic [TAG_W-1:0] rob_id;
    logic [31:0]      vj;
    logic [TAG_W-1:0] qj;
    logic [31:0]      vk;
    logic [TAG_W-1:0] qk;
    logic [31:0]      imm;
    logic             announced;
    logic             committed;
  } lsb_entry_t;

  function automatic logic [1:0] funct3_to_len(input logic [2:0] f3);
    logic [1:0] len;
    case (f3)
      F3_B, F3_BU: len = LEN_BYTE;
      F3_H, F3_HU: len = LEN_HALF;
      default:     len = LEN_WORD;
    endcase
    return len;
  endfunction

  // A waiting operand (tag != 0) captures the value of whichever valid bus
  // carries its tag and becomes ready.
  function automatic lsb_entry_t snoop(
    input lsb_entry_t       e,
    input logic             a_v,
    input logic [TAG_W-1:0] a_tag,
    input logic [31:0]      a_val,
    input logic             b_v,
    input logic [TAG_W-1:0] b_tag,
    input logic [31:0]      b_val
  );
    lsb_entry_t r;
    r = e;
    if (e.qj != 5'd0 && a_v && e.qj == a_tag) begin
      r.vj = a_val;
      r.qj = 5'd0;
    end else if (e.qj != 5'd0 && b_v && e.qj == b_tag) begin
      r.vj = b_val;
      r.qj = 5'd0;
    end else begin
      r.qj = e.qj;
    end
    if (e.qk != 5'd0 && a_v && e.qk == a_tag) begin
      r.vk = a_val;
      r.qk = 5'd0;
    end else if (e.qk != 5'd0 && b_v && e.qk == b_tag) begin
      r.vk = b_val;
      r.qk = 5'd0;
    end else begin
      r.qk = e.qk;
    end
    return r;
  endfunction

endpackage

// File: rtl/load_store_buffer_load_extend.sv
// Load result formatting: turns zero-extended raw memory data into the
// architectural load result according to funct3.
// Ports:
//   i_funct3 : load width/sign code
//   i_rdata  : raw data from memory, already zero-extended
//   o_result : sign- or zero-extended 32-bit load result
module lsb_load_extend
  import load_store_buffer_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_result
);

  // Select extension by width and signedness
  always_comb begin
    case (i_funct3)
      F3_B:    o_result = {{24{i_rdata[7]}}, i_rdata[7:0]};
      F3_H:    o_result = {{16{i_rdata[15]}}, i_rdata[15:0]};
      F3_BU:   o_result = {24'd0, i_rdata[7:0]};
      F3_HU:   o_result = {16'd0, i_rdata[15:0]};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_buffer.sv
// Load/store buffer: in-order circular queue of memory operations for a
// Tomasulo-style core. Only the head entry talks to memory.
// Ports:
//   clk, rst (sync, active-high), rdy (global stall), wrong_commit (flush)
//   dispatch_*      : enqueue interface (tags of 0 mean operand ready)
//   lsb_full        : occupancy >= DEPTH-1
//   alu_*           : ALU result bus, snooped for wakeup
//   lsb_valid/_rob_id/_res : result broadcast (load data, or 0 for store ready)
//   ls_commit/ls_rob_id    : reorder buffer commits a store
//   mem_req/_wr/_len/_addr/_wdata, mem_done, mem_rdata : memory port
module load_store_buffer
  import load_store_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             wrong_commit,
  input  logic             dispatch_valid,
  input  logic             dispatch_store,
  input  logic [2:0]       dispatch_funct3,
  input  logic [TAG_W-1:0] dispatch_rob_id,
  input  logic [TAG_W-1:0] dispatch_Qj,
  input  logic [TAG_W-1:0] dispatch_Qk,
  input  logic [31:0]      dispatch_Vj,
  input  logic [31:0]      dispatch_Vk,
  input  logic [31:0]      dispatch_imm,
  output logic             lsb_full,
  input  logic             alu_valid,
  input  logic [TAG_W-1:0] alu_rob_id,
  input  logic [31:0]      alu_res,
  output logic             lsb_valid,
  output logic [TAG_W-1:0] lsb_rob_id,
  output logic [31:0]      lsb_res,
  input  logic             ls_commit,
  input  logic [TAG_W-1:0] ls_rob_id,
  output logic             mem_req,
  output logic             mem_wr,
  output logic [1:0]       mem_len,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_done,
  input  logic [31:0]      mem_rdata
);

  lsb_entry_t       r_q     [DEPTH];
  lsb_entry_t       w_q_nxt [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail, w_head_nxt, w_tail_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt, w_kept;
  lsb_state_e       r_state, w_state_nxt;

  logic             r_lsb_full, r_lsb_valid, r_mem_req, r_mem_wr;
  logic [TAG_W-1:0] r_lsb_rob_id;
  logic [31:0]      r_lsb_res, r_mem_addr, r_mem_wdata;
  logic [1:0]       r_mem_len;

  logic             w_lsb_valid_nxt, w_mem_req_nxt, w_mem_wr_nxt;
  logic [TAG_W-1:0] w_lsb_rob_id_nxt;
  logic [31:0]      w_lsb_res_nxt, w_mem_addr_nxt, w_mem_wdata_nxt;
  logic [1:0]       w_mem_len_nxt;

  lsb_entry_t  w_head_e;
  logic        w_nonempty, w_pop, w_enq;
  logic        w_load_go, w_store_go, w_announce;
  logic [31:0] w_addr, w_ext_res;

  assign w_head_e   = r_q[r_head];
  assign w_nonempty = (r_count != 5'd0);
  assign w_pop      = (r_state != ST_IDLE) && mem_done;
  assign w_enq      = dispatch_valid && (r_count < CNT_W'(DEPTH)) && !wrong_commit;
  assign w_addr     = w_head_e.vj + w_head_e.imm;

  // A load may start as soon as its base is known; it is dropped by a flush.
  assign w_load_go  = (r_state == ST_IDLE) && w_nonempty && !w_head_e.store &&
                      (w_head_e.qj == 5'd0) && !wrong_commit;
  // A committed store survives a flush, so it may start regardless.
  assign w_store_go = (r_state == ST_IDLE) && w_nonempty && w_head_e.store &&
                      w_head_e.committed && (w_head_e.qj == 5'd0) && (w_head_e.qk == 5'd0);
  assign w_announce = (r_state == ST_IDLE) && w_nonempty && w_head_e.store &&
                      !w_head_e.committed && !w_head_e.announced &&
                      (w_head_e.qj == 5'd0) && (w_head_e.qk == 5'd0) && !wrong_commit;

  lsb_load_extend u_load_extend (
    .i_funct3 (w_head_e.funct3),
    .i_rdata  (mem_rdata),
    .o_result (w_ext_res)
  );

  // Next queue contents: wakeup, store commit marking, announce flag, enqueue
  always_comb begin : queue_next
    lsb_entry_t       v_new;
    logic [PTR_W-1:0] v_off;
    v_off = 4'd0;
    v_new = '0;
    v_new.store  = dispatch_store;
    v_new.funct3 = dispatch_funct3;
    v_new.rob_id = dispatch_rob_id;
    v_new.vj     = dispatch_Vj;
    v_new.qj     = dispatch_Qj;
    v_new.vk     = dispatch_Vk;
    v_new.qk     = dispatch_Qk;
    v_new.imm    = dispatch_imm;
    v_new = snoop(v_new, alu_valid, alu_rob_id, alu_res, r_lsb_valid, r_lsb_rob_id, r_lsb_res);
    for (int i = 0; i < DEPTH; i++) begin
      w_q_nxt[i] = r_q[i];
    end
    if (!wrong_commit) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_q_nxt[i] = snoop(r_q[i], alu_valid, alu_rob_id, alu_res,
                           r_lsb_valid, r_lsb_rob_id, r_lsb_res);
        // Only live entries may be committed; stale slots can alias a tag.
        v_off = PTR_W'(i) - r_head;
        if (ls_commit && ({1'b0, v_off} < r_count) && r_q[i].store &&
            (r_q[i].rob_id == ls_rob_id)) begin
          w_q_nxt[i].committed = 1'b1;
        end else begin
          w_q_nxt[i].committed = r_q[i].committed;
        end
      end
      if (w_announce) begin
        w_q_nxt[r_head].announced = 1'b1;
      end else begin
        w_q_nxt[r_head].announced = r_q[r_head].announced;
      end
      if (w_enq) begin
        w_q_nxt[r_tail] = v_new;
      end else begin
        w_q_nxt[r_tail] = w_q_nxt[r_tail];
      end
    end else begin
      v_off = 4'd0;
    end
  end

  // Entries surviving a flush: an in-flight load at the head (it must drain)
  // followed by the run of committed stores.
  always_comb begin : flush_keep
    logic             v_run;
    logic [PTR_W-1:0] v_idx;
    w_kept = 5'd0;
    v_run  = 1'b1;
    v_idx  = 4'd0;
    for (int k = 0; k < DEPTH; k++) begin
      v_idx = r_head + PTR_W'(k);
      if (v_run && (CNT_W'(k) < r_count) &&
          (((k == 0) && (r_state == ST_LOAD || r_state == ST_DRAIN)) ||
           (r_q[v_idx].store && r_q[v_idx].committed))) begin
        w_kept = w_kept + 5'd1;
      end else begin
        v_run = 1'b0;
      end
    end
  end

  // Head/tail/count update
  always_comb begin
    if (wrong_commit) begin
      w_head_nxt  = r_head + {3'b000, w_pop};
      w_tail_nxt  = r_head + w_kept[PTR_W-1:0];
      w_count_nxt = w_kept - {4'b0000, w_pop};
    end else begin
      w_head_nxt  = r_head + {3'b000, w_pop};
      w_tail_nxt  = r_tail + {3'b000, w_enq};
      w_count_nxt = r_count + {4'b0000, w_enq} - {4'b0000, w_pop};
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (rdy) begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_load_go) begin
          w_state_nxt = ST_LOAD;
        end else if (w_store_go) begin
          w_state_nxt = ST_STORE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (mem_done) begin
          w_state_nxt = ST_IDLE;
        end else if (wrong_commit) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_STORE, ST_DRAIN: begin
        if (mem_done) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs
  always_comb begin
    w_mem_req_nxt    = r_mem_req;
    w_mem_wr_nxt     = r_mem_wr;
    w_mem_len_nxt    = r_mem_len;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_lsb_valid_nxt  = 1'b0;
    w_lsb_rob_id_nxt = r_lsb_rob_id;
    w_lsb_res_nxt    = r_lsb_res;
    case (r_state)
      ST_IDLE: begin
        if (w_load_go || w_store_go) begin
          w_mem_req_nxt   = 1'b1;
          w_mem_wr_nxt    = w_store_go;
          w_mem_len_nxt   = funct3_to_len(w_head_e.funct3);
          w_mem_addr_nxt  = w_addr;
          w_mem_wdata_nxt = w_store_go ? w_head_e.vk : 32'd0;
        end else if (w_announce) begin
          w_lsb_valid_nxt  = 1'b1;
          w_lsb_rob_id_nxt = w_head_e.rob_id;
          w_lsb_res_nxt    = 32'd0;
        end else begin
          w_mem_req_nxt = r_mem_req;
        end
      end
      ST_LOAD: begin
        if (mem_done) begin
          w_mem_req_nxt = 1'b0;
          w_mem_wr_nxt  = 1'b0;
          // A flush landing with the data suppresses the result.
          if (!wrong_commit) begin
            w_lsb_valid_nxt  = 1'b1;
            w_lsb_rob_id_nxt = w_head_e.rob_id;
            w_lsb_res_nxt    = w_ext_res;
          end else begin
            w_lsb_valid_nxt = 1'b0;
          end
        end else begin
          w_mem_req_nxt = r_mem_req;
        end
      end
      ST_STORE, ST_DRAIN: begin
        if (mem_done) begin
          w_mem_req_nxt = 1'b0;
          w_mem_wr_nxt  = 1'b0;
        end else begin
          w_mem_req_nxt = r_mem_req;
        end
      end
      default: w_mem_req_nxt = 1'b0;
    endcase
  end

  // Queue, pointers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
      r_head       <= 4'd0;
      r_tail       <= 4'd0;
      r_count      <= 5'd0;
      r_lsb_full   <= 1'b0;
      r_lsb_valid  <= 1'b0;
      r_lsb_rob_id <= 5'd0;
      r_lsb_res    <= 32'd0;
      r_mem_req    <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_len    <= 2'd0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
    end else if (rdy) begin
      r_q          <= w_q_nxt;
      r_head       <= w_head_nxt;
      r_tail       <= w_tail_nxt;
      r_count      <= w_count_nxt;
      r_lsb_full   <= (w_count_nxt >= CNT_W'(DEPTH - 1));
      r_lsb_valid  <= w_lsb_valid_nxt;
      r_lsb_rob_id <= w_lsb_rob_id_nxt;
      r_lsb_res    <= w_lsb_res_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_wr     <= w_mem_wr_nxt;
      r_mem_len    <= w_mem_len_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
    end
  end

  assign lsb_full   = r_lsb_full;
  assign lsb_valid  = r_lsb_valid;
  assign lsb_rob_id = r_lsb_rob_id;
  assign lsb_res    = r_lsb_res;
  assign mem_req    = r_mem_req;
  assign mem_wr     = r_mem_wr;
  assign mem_len    = r_mem_len;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule
